// File: rtl/agu_pkg.sv
// agu_pkg: shared FSM states and access-size codes
// for the split load/store address-generation unit.
package agu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1,
        WB
    } agu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

endpackage

// File: rtl/agu_ld_merge.sv
// agu_ld_merge: joins two read beats, shifts the
// addressed bytes down and sign/zero-extends them.
module agu_ld_merge
    import agu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] beat0,
    input  logic [XLEN-1:0] beat1,
    input  logic [OW-1:0]   off,
    input  logic [1:0]      size,
    input  logic            usign,
    output logic [XLEN-1:0] data
);

    localparam int IW = $clog2(2 * XLEN);

    logic [2*XLEN-1:0] wide;
    logic [XLEN-1:0]   keep;
    logic [IW-1:0]     sidx;
    logic              sbit;
    int                nbits;

    // Byte-align the access, then fill above the top byte.
    always_comb begin
        wide = {beat1, beat0} >> {off, 3'b000};
        case (size)
            SZ_B:    nbits = 8;
            SZ_H:    nbits = 16;
            SZ_W:    nbits = 32;
            default: nbits = 64;
        endcase
        sidx = IW'(nbits - 1);
        sbit = ~usign & wide[sidx];
        keep = ~({XLEN{1'b1}} << nbits);
        data = (wide[XLEN-1:0] & keep)
             | ({XLEN{sbit}} & ~keep);
    end

endmodule

// File: rtl/agu_split.sv
// agu_split: handshaked single-outstanding AGU and bus front end.
// Define AGU_MISALGN_SPLIT_EN to split word-straddling accesses.
module agu_split
    import agu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_load,
    input  logic              i_store,
    input  logic              i_usign,
    input  logic [1:0]        i_size,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_read,
    output logic [XLEN-1:0]   cmd_addr,
    output logic [XLEN-1:0]   cmd_wdata,
    output logic [XLEN/8-1:0] cmd_wmask,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_data,
    input  logic              rsp_err,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [XLEN-1:0]   o_data,
    output logic              o_err,
    output logic              o_misalgn
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    agu_state_e state_q, state_d;

    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_read_q, cmd_read_d;
    logic [XLEN-1:0] cmd_addr_q, cmd_addr_d;
    logic [XLEN-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [NB-1:0]   cmd_wmask_q, cmd_wmask_d;
    logic            o_valid_q, o_valid_d;
    logic [XLEN-1:0] o_data_q, o_data_d;
    logic            o_err_q, o_err_d;
    logic            o_misalgn_q, o_misalgn_d;
    logic [OW-1:0]   off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            usign_q, usign_d;

    logic [XLEN-1:0] addr, base, rs2_t;
    logic [XLEN-1:0] lo_wdata;
    logic [NB-1:0]   lo_wmask;
    logic [OW-1:0]   off;
    logic [3:0]      nbytes;
    logic            ld, ill, mis;
    logic [XLEN-1:0] m_b0, m_b1, m_data;

`ifdef AGU_MISALGN_SPLIT_EN
    logic [2*XLEN-1:0] wide_w;
    logic [2*NB-1:0]   wide_m;
    logic              spl;
    logic              split_q, split_d;
    logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
    logic [NB-1:0]     hi_wmask_q, hi_wmask_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
`endif

    assign i_ready   = (state_q == IDLE);
    assign cmd_valid = cmd_valid_q;
    assign cmd_read  = cmd_read_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign cmd_wmask = cmd_wmask_q;
    assign o_valid   = o_valid_q;
    assign o_data    = o_data_q;
    assign o_err     = o_err_q;
    assign o_misalgn = o_misalgn_q;

    // Issue-side decode: address, lane offset, data and masks.
    always_comb begin
        addr   = i_rs1 + i_imm;
        off    = addr[OW-1:0];
        base   = {addr[XLEN-1:OW], {OW{1'b0}}};
        nbytes = 4'd1 << i_size;
        ld     = i_load & ~i_store;
        ill    = (XLEN == 32) && (i_size == SZ_D);
        mis    = (32'(off) & (32'(nbytes) - 32'd1)) != 32'd0;
        rs2_t  = i_rs2 & ~({XLEN{1'b1}} << {nbytes, 3'b000});
`ifdef AGU_MISALGN_SPLIT_EN
        spl      = (32'(off) + 32'(nbytes)) > 32'(NB);
        wide_w   = {{XLEN{1'b0}}, rs2_t} << {off, 3'b000};
        wide_m   = (2*NB)'((32'd1 << nbytes) - 32'd1) << off;
        lo_wdata = wide_w[XLEN-1:0];
        lo_wmask = wide_m[NB-1:0];
`else
        lo_wdata = rs2_t << {off, 3'b000};
        lo_wmask = NB'((32'd1 << nbytes) - 32'd1) << off;
`endif
    end

    // Second-beat responses merge with the held first beat.
    always_comb begin
        m_b0 = rsp_data;
        m_b1 = '0;
`ifdef AGU_MISALGN_SPLIT_EN
        if (state_q == RSP1) begin
            m_b0 = beat0_q;
            m_b1 = rsp_data;
        end
`endif
    end

    agu_ld_merge #(.XLEN(XLEN)) u_merge (
        .beat0 (m_b0),
        .beat1 (m_b1),
        .off   (off_q),
        .size  (size_q),
        .usign (usign_q),
        .data  (m_data)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_read_d  = cmd_read_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wmask_d = cmd_wmask_q;
        o_valid_d   = o_valid_q;
        o_data_d    = o_data_q;
        o_err_d     = o_err_q;
        o_misalgn_d = o_misalgn_q;
        off_d       = off_q;
        size_d      = size_q;
        usign_d     = usign_q;
`ifdef AGU_MISALGN_SPLIT_EN
        split_d     = split_q;
        hi_wdata_d  = hi_wdata_q;
        hi_wmask_d  = hi_wmask_q;
        beat0_d     = beat0_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    o_misalgn_d = mis;
                    o_data_d    = '0;
                    o_err_d     = 1'b0;
`ifdef AGU_MISALGN_SPLIT_EN
                    if (ill) begin
`else
                    if (ill || mis) begin
`endif
                        state_d   = WB;
                        o_valid_d = 1'b1;
                        o_err_d   = 1'b1;
                    end else begin
                        state_d     = REQ0;
                        cmd_valid_d = 1'b1;
                        cmd_read_d  = ld;
                        cmd_addr_d  = base;
                        cmd_wdata_d = ld ? '0 : lo_wdata;
                        cmd_wmask_d = lo_wmask;
                        off_d       = off;
                        size_d      = i_size;
                        usign_d     = i_usign;
`ifdef AGU_MISALGN_SPLIT_EN
                        split_d     = spl;
                        hi_wdata_d  = ld ? '0 : wide_w[2*XLEN-1:XLEN];
                        hi_wmask_d  = wide_m[2*NB-1:NB];
`endif
                    end
                end
            end
            REQ0: begin
                if (cmd_ready) begin
                    state_d     = RSP0;
                    cmd_valid_d = 1'b0;
                end
            end
            RSP0: begin
                if (rsp_valid) begin
`ifdef AGU_MISALGN_SPLIT_EN
                    if (split_q && !rsp_err) begin
                        state_d     = REQ1;
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = cmd_addr_q + XLEN'(NB);
                        cmd_wdata_d = hi_wdata_q;
                        cmd_wmask_d = hi_wmask_q;
                        beat0_d     = rsp_data;
                    end else begin
`else
                    begin
`endif
                        state_d   = WB;
                        o_valid_d = 1'b1;
                        o_err_d   = rsp_err;
                        o_data_d  = (cmd_read_q && !rsp_err)
                                  ? m_data : '0;
                    end
                end
            end
`ifdef AGU_MISALGN_SPLIT_EN
            REQ1: begin
                if (cmd_ready) begin
                    state_d     = RSP1;
                    cmd_valid_d = 1'b0;
                end
            end
            RSP1: begin
                if (rsp_valid) begin
                    state_d   = WB;
                    o_valid_d = 1'b1;
                    o_err_d   = o_err_q | rsp_err;
                    o_data_d  = (cmd_read_q && !rsp_err)
                              ? m_data : '0;
                end
            end
`endif
            WB: begin
                if (o_ready) begin
                    state_d   = IDLE;
                    o_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            o_err_q     <= 1'b0;
            o_misalgn_q <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            usign_q     <= 1'b0;
`ifdef AGU_MISALGN_SPLIT_EN
            split_q     <= 1'b0;
            hi_wdata_q  <= '0;
            hi_wmask_q  <= '0;
            beat0_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_read_q  <= cmd_read_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wmask_q <= cmd_wmask_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_err_q     <= o_err_d;
            o_misalgn_q <= o_misalgn_d;
            off_q       <= off_d;
            size_q      <= size_d;
            usign_q     <= usign_d;
`ifdef AGU_MISALGN_SPLIT_EN
            split_q     <= split_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_wmask_q  <= hi_wmask_d;
            beat0_q     <= beat0_d;
`endif
        end
    end

endmodule

// File: tb/tb_agu_split.sv
// tb_agu_split: directed and random accesses against a
// byte-level reference model of the split AGU (XLEN=32).
module tb_agu_split;

    localparam int XLEN = 32;
`ifdef AGU_MISALGN_SPLIT_EN
    localparam int SPL = 1;
`else
    localparam int SPL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready;
    logic [31:0] i_rs1, i_rs2, i_imm;
    logic        i_load, i_store, i_usign;
    logic [1:0]  i_size;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        o_valid, o_ready;
    logic [31:0] o_data;
    logic        o_err, o_misalgn;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    agu_split #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_imm     (i_imm),
        .i_load    (i_load),
        .i_store   (i_store),
        .i_usign   (i_usign),
        .i_size    (i_size),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wmask (cmd_wmask),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_err     (o_err),
        .o_misalgn (o_misalgn)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // One access; called and returning at a negedge.
    task automatic access(input logic [31:0] rs1,
                          input logic [31:0] imm,
                          input logic [31:0] rs2,
                          input bit ld, input bit us,
                          input logic [1:0] sz,
                          input logic [31:0] d0,
                          input logic [31:0] d1,
                          input bit e0,
                          input int rw, input int sw,
                          input int ow, input int ecyc);
        logic [31:0] addr, eres, edat;
        logic [31:0] ea [2];
        logic [31:0] ew [2];
        logic [3:0]  em [2];
        logic [31:0] dd [2];
        int off, nb, nbeats, c, n, p;
        bit ill, mis, spl, nobus, eerr;
        addr = rs1 + imm;
        off  = int'(addr % 32'd4);
        nb   = 1 << sz;
        ill  = (sz == 2'b11);
        mis  = (off % nb) != 0;
        spl  = (off + nb) > 4;
        nobus = ill || (SPL == 0 && mis);
        ea[0] = addr & ~32'h3;
        ea[1] = ea[0] + 32'd4;
        ew[0] = '0; ew[1] = '0;
        em[0] = '0; em[1] = '0;
        dd[0] = d0;
        dd[1] = spl ? d1 : 32'h0;
        eres = '0;
        for (int k = 0; k < nb && !ill; k++) begin
            p = off + k;
            ew[p/4][8*(p%4) +: 8] = rs2[8*k +: 8];
            em[p/4][p%4] = 1'b1;
            eres[8*k +: 8] = dd[p/4][8*(p%4) +: 8];
        end
        if (!us && !ill && eres[8*nb-1])
            for (int b = 8 * nb; b < 32; b++) eres[b] = 1'b1;
        nbeats = nobus ? 0 : ((spl && !e0) ? 2 : 1);
        eerr = nobus || e0;
        edat = (nobus || !ld || e0) ? 32'h0 : eres;

        chk("i_ready_idle", i_ready, 1);
        i_valid = 1'b1; i_rs1 = rs1; i_imm = imm;
        i_rs2 = rs2; i_load = ld; i_store = !ld;
        i_usign = us; i_size = sz;
        @(negedge clk);
        i_valid = 1'b0;
        c = 1;
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            while (!cmd_valid && n < 50) begin
                @(negedge clk); c++; n++;
            end
            chk("cmd_valid", cmd_valid, 1);
            for (int w = 0; w <= rw; w++) begin
                chk("cmd_addr", cmd_addr, ea[b]);
                chk("cmd_read", cmd_read, ld);
                chk("cmd_wmask", cmd_wmask, em[b]);
                if (!ld) chk("cmd_wdata", cmd_wdata, ew[b]);
                if (w == rw) cmd_ready = 1'b1;
                @(negedge clk); c++;
            end
            cmd_ready = 1'b0;
            repeat (sw) begin @(negedge clk); c++; end
            rsp_valid = 1'b1;
            rsp_data  = dd[b];
            rsp_err   = (b == 0) ? e0 : 1'b0;
            @(negedge clk); c++;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            rsp_data  = $urandom;
        end
        n = 0;
        while (!o_valid && n < 50) begin
            chk("no_extra_cmd", cmd_valid, 0);
            @(negedge clk); c++; n++;
        end
        chk("o_valid", o_valid, 1);
        if (ecyc >= 0) chk("latency", c, ecyc);
        for (int w = 0; w <= ow; w++) begin
            chk("o_valid_hold", o_valid, 1);
            chk("o_data", o_data, edat);
            chk("o_err", o_err, eerr);
            if (!ill) chk("o_misalgn", o_misalgn, mis);
            chk("cmd_idle_wb", cmd_valid, 0);
            if (w == ow) o_ready = 1'b1;
            @(negedge clk);
        end
        o_ready = 1'b0;
        chk("o_valid_drop", o_valid, 0);
        chk("i_ready_back", i_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0;
        i_rs1 = '0; i_rs2 = '0; i_imm = '0;
        i_load = 1'b0; i_store = 1'b0;
        i_usign = 1'b0; i_size = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_data = '0; rsp_err = 1'b0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_i_ready", i_ready, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // sw split store across 0x1002
        access(32'h1000, 32'h2, 32'hAABBCCDD, 0, 0, 2'b10,
               0, 0, 0, 0, 0, 0, SPL ? 5 : 1);
        // lh signed at 0x2003
        access(32'h2000, 32'h3, 0, 1, 0, 2'b01,
               32'h80112233, 32'h445566F7, 0, 0, 0, 0,
               SPL ? 5 : 1);
        // lbu at 0x3001
        access(32'h3000, 32'h1, 0, 1, 1, 2'b00,
               32'h1234ABCD, 0, 0, 0, 0, 0, 3);
        // split lw with beat-0 error
        access(32'h4000, 32'h6, 0, 1, 0, 2'b10,
               32'h11111111, 32'h22222222, 1, 0, 0, 0, -1);
        // lw at 0x5001
        access(32'h5000, 32'h1, 0, 1, 0, 2'b10,
               32'hDEADBEEF, 32'hCAFEF00D, 0, 1, 1, 1, -1);
        // doubleword is illegal at XLEN=32
        access(32'h6000, 32'h0, 32'h5, 1, 0, 2'b11,
               0, 0, 0, 0, 0, 0, 1);
        // aligned lw, zero-wait
        access(32'h7000, 32'h4, 0, 1, 0, 2'b10,
               32'h89ABCDEF, 0, 0, 0, 0, 0, 3);
        // beat-1 address wraps to zero
        access(32'hFFFFFFFE, 32'h0, 0, 1, 1, 2'b10,
               32'hA1B2C3D4, 32'h0F1E2D3C, 0, 0, 0, 0, -1);
        // negative offset, sh with stalls
        access(32'h8010, 32'hFFFFFFFE, 32'h1234BEEF, 0, 0,
               2'b01, 0, 0, 0, 2, 2, 2, -1);

        // rsp_valid while idle must be ignored
        rsp_valid = 1'b1; rsp_data = 32'hFFFFFFFF;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("stray_rsp_ready", i_ready, 1);
        chk("stray_rsp_oval", o_valid, 0);
        chk("stray_rsp_cmd", cmd_valid, 0);

        // reset mid-access with a beat pending
        i_valid = 1'b1; i_rs1 = 32'h1000;
        i_imm = SPL ? 32'h2 : 32'h4;
        i_rs2 = 32'hAABBCCDD; i_load = 1'b0;
        i_store = 1'b1; i_size = 2'b10;
        @(negedge clk);
        i_valid = 1'b0;
        if (SPL != 0) begin
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0; rsp_valid = 1'b1;
            @(negedge clk);
            rsp_valid = 1'b0;
        end
        chk("pre_rst_cmd", cmd_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_i_ready", i_ready, 1);
        chk("mid_rst_cmd_valid", cmd_valid, 0);
        chk("mid_rst_cmd_read", cmd_read, 0);
        chk("mid_rst_cmd_addr", cmd_addr, 0);
        chk("mid_rst_cmd_wdata", cmd_wdata, 0);
        chk("mid_rst_cmd_wmask", cmd_wmask, 0);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_data", o_data, 0);
        chk("mid_rst_o_err", o_err, 0);
        chk("mid_rst_o_misalgn", o_misalgn, 0);
        repeat (2) @(negedge clk);
        chk("dropped_beat", cmd_valid, 0);

        // random accesses
        for (int t = 0; t < 60; t++) begin
            logic [1:0] sz;
            int r;
            r  = $urandom_range(0, 9);
            sz = (r < 9) ? 2'(r % 3) : 2'b11;
            access($urandom, 32'($urandom_range(0, 15)),
                   $urandom, 1'($urandom), 1'($urandom),
                   sz, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 2),
                   $urandom_range(0, 2),
                   $urandom_range(0, 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
